des_key_schedule: RTL and testbench
===================================

Name: des_key_schedule

Overview:
- Iterative DES key schedule that sits directly downstream of the key-tamper stage.
- Consumes its 56-bit (post-PC-1, parity-stripped) key output and emits the sixteen 48-bit round subkeys, one per accepted handshake, to the DES round datapath.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1).
- The schedule never inspects or corrects the key; a tampered key propagates unchanged into every subkey.

Parameters:
- NUM_ROUNDS, 16, rounds per key; fixed at 16 for DES, exposed only for the round-counter width check.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  load key_in and begin a schedule; honoured only when busy=0.
- decrypt  input  1  sampled with start; 0 = K1 first, 1 = K16 first.
- key_in  input  56  post-PC-1 key; C0 = key_in[55:28], D0 = key_in[27:0]; DES bit 1 = key_in[55].
- subkey_ready  input  1  downstream accepts the current subkey this cycle.
- subkey  output  48  PC-2 of the current {C,D}; DES bit 1 = subkey[47].
- subkey_valid  output  1  subkey holds a round key awaiting acceptance.
- round  output  4  0-based index of the subkey's DES round: 0 = K1, 15 = K16.
- busy  output  1  schedule in progress.
- done  output  1  one-cycle pulse on acceptance of the final subkey.

Behaviour:
- Reset (asynchronous, rst=1): all outputs and state go to 0, FSM to IDLE. Reset mid-schedule aborts it; no done pulse is generated.
- FSM states: IDLE, RUN.
- IDLE:
  - start=1 at edge T: capture mode.
  - Encrypt: C,D = key_in halves rotated left by 1.
  - Decrypt: C,D = key_in unrotated.
  - Step counter = 0; go to RUN.
  - At T+1: subkey_valid=1, busy=1.
- RUN:
  - subkey = PC-2({C,D}), driven combinationally from the C/D registers.
  - round = step (encrypt) or 15-step (decrypt).
  - On subkey_valid & subkey_ready:
    - If step < 15: step++ and rotate C and D.
    - Encrypt rotates left by shift[step+1].
    - Decrypt rotates right by shift[15-step].
  - shift[0..15] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Check: total rotation per schedule is 28 in both modes, so C,D return to C0,D0.
  - subkey_ready=0 holds subkey, round, C and D stable, with subkey_valid staying 1.
  - With subkey_ready held high, consecutive subkeys appear on T+1..T+16.
- Final acceptance (step=15 & subkey_ready):
  - done=1 for one cycle, on the following edge.
  - busy=0, subkey_valid=0, FSM to IDLE.
  - subkey and round keep their last values.
- start while busy=1 is ignored; key_in and decrypt changes mid-schedule have no effect.
- start in the same cycle done asserts is legal, because busy is already 0. The new schedule's first subkey is valid the next cycle.
- Rotations wrap within each 28-bit half; C and D never mix.

Decomposition:
- Shared package des_pkg holds:
  - PC-2 index table (48 entries, DES 1-based numbering).
  - Shift schedule constant.
  - Widths KEY_W=56, HALF_W=28, SUBKEY_W=48.
  - FSM state enum.
- One combinational sub-module des_pc2: 56-bit {C,D} in, 48-bit subkey out. The schedule instantiates it once.
- The remainder is the FSM, step counter and rotate logic in des_key_schedule.

Test Plan:
- Encrypt, standard vector: key_in=0xF0CCAAF556678F (key 133457799BBCDFF1), decrypt=0, start, subkey_ready=1.
  - Subkey_valid high T+1..T+16.
  - round=0 subkey=0x1B02EFFC7072 at T+1.
  - round=15 subkey=0xCB3D8B0E17F5 at T+16.
  - done pulse at T+17, busy low T+17.
- Decrypt, same key, decrypt=1:
  - First subkey=0xCB3D8B0E17F5 with round=15.
  - Last subkey=0x1B02EFFC7072 with round=0.
  - Each round's value equals the encrypt run's value for the same round.
- Backpressure, encrypt vector: drop subkey_ready for 3 cycles while round=4.
  - subkey and round frozen, subkey_valid=1.
  - Schedule completes with identical sixteen values; done delayed by 3 cycles.
- start pulsed at round=7 with key_in=0: ignored, remaining subkeys match the vector.
- Assert rst at round=9:
  - All outputs go 0 immediately, asynchronously.
  - No done pulse.
  - A new start after release runs a clean schedule.
- Tampered key: key_in=0x00000000000001 vs 0.
  - Zero key gives all 16 subkeys 0.
  - Flipped-LSB key gives a nonzero subkey in at least one round; that subkey is bit-exact against a software DES model.

Source files
------------

// File: rtl/des_pkg.sv
// Shared constants for the DES key schedule: widths, the PC-2 table, the
// per-round shift amounts, the FSM state type and a half-key rotate helper.
package des_pkg;
  localparam int KEY_W    = 56;
  localparam int HALF_W   = 28;
  localparam int SUBKEY_W = 48;

  // PC-2 selection in DES 1-based numbering over {C,D}; entry 0 is subkey bit 1.
  localparam int PC2 [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ks_state_e;

  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic [1:0] n);
    case (n)
      2'd2:    return {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
      2'd1:    return {x[HALF_W-2:0], x[HALF_W-1]};
      default: return x;
    endcase
  endfunction

  function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic [1:0] n);
    case (n)
      2'd2:    return {x[1:0], x[HALF_W-1:2]};
      2'd1:    return {x[0], x[HALF_W-1:1]};
      default: return x;
    endcase
  endfunction
endpackage

// File: rtl/des_pc2.sv
// PC-2 compression: pure wiring from the 56-bit {C,D} to the 48-bit subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [KEY_W-1:0]    cd,
  output logic [SUBKEY_W-1:0] subkey
);
  // DES bit n of the 56-bit word lives at cd[KEY_W-n].
  for (genvar i = 0; i < SUBKEY_W; i++) begin : g_sel
    assign subkey[SUBKEY_W-1-i] = cd[KEY_W-PC2[i]];
  end
endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one subkey per accepted handshake, in
// encrypt (K1..K16) or decrypt (K16..K1) order. The key is never altered.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                decrypt,
  input  logic [KEY_W-1:0]    key_in,
  input  logic                subkey_ready,
  output logic [SUBKEY_W-1:0] subkey,
  output logic                subkey_valid,
  output logic [3:0]          round,
  output logic                busy,
  output logic                done
);
  if (NUM_ROUNDS != 16) begin : g_bad_rounds
    $error("des_key_schedule: NUM_ROUNDS must be 16 to fit the 4-bit round counter");
  end

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);

  ks_state_e         state, state_n;
  logic [HALF_W-1:0] c, c_n, d, d_n;
  logic [3:0]        step, step_n;
  logic              dec, dec_n, done_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      c     <= '0;
      d     <= '0;
      step  <= '0;
      dec   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      c     <= c_n;
      d     <= d_n;
      step  <= step_n;
      dec   <= dec_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    c_n     = c;
    d_n     = d;
    step_n  = step;
    dec_n   = dec;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          dec_n   = decrypt;
          step_n  = '0;
          state_n = RUN;
          // Decrypt starts from C16,D16, which equal C0,D0 (total rotation 28).
          if (decrypt) begin
            c_n = key_in[KEY_W-1:HALF_W];
            d_n = key_in[HALF_W-1:0];
          end else begin
            c_n = rotl(key_in[KEY_W-1:HALF_W], SHIFT[0]);
            d_n = rotl(key_in[HALF_W-1:0], SHIFT[0]);
          end
        end
      end
      RUN: begin
        if (subkey_ready) begin
          if (step == LAST) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            step_n = step + 4'd1;
            if (dec) begin
              c_n = rotr(c, SHIFT[4'd15 - step]);
              d_n = rotr(d, SHIFT[4'd15 - step]);
            end else begin
              c_n = rotl(c, SHIFT[step + 4'd1]);
              d_n = rotl(d, SHIFT[step + 4'd1]);
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  des_pc2 u_pc2 (
    .cd     ({c, d}),
    .subkey (subkey)
  );

  assign subkey_valid = (state == RUN);
  assign busy         = (state == RUN);
  assign round        = dec ? (4'd15 - step) : step;
endmodule

// File: tb/tb_des_key_schedule.sv
// Directed checks of the DES key schedule against the published K1..K16
// for key 133457799BBCDFF1 and hand-derived subkeys for a single-bit key.
module tb_des_key_schedule;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic [55:0] key_in = '0;
  logic        subkey_ready = 1'b0;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [55:0] KSTD = 56'hF0CCAAF556678F;

  logic [47:0] kstd [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  // key_in = 1: only DES key bit 56 (D bit 28) set; its path through the
  // rotations and PC-2 was traced by hand for each round.
  logic [47:0] klsb [16] = '{
    48'h000000040000, 48'h000000000000, 48'h000000400000, 48'h000000000008,
    48'h000000001000, 48'h000000000020, 48'h000000000800, 48'h000000000010,
    48'h000000800000, 48'h000000000200, 48'h000000100000, 48'h000000000000,
    48'h000000002000, 48'h000000200000, 48'h000000000002, 48'h000000000100
  };

  des_key_schedule #(.NUM_ROUNDS(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .decrypt      (decrypt),
    .key_in       (key_in),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .round        (round),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel: 0 = standard key table, 1 = single-bit key table, 2 = all-zero subkeys
  task automatic run(input string nm, input logic [55:0] k, input bit dm, input int sel,
                     input int stall_at, input int stall_len, input int poke_at);
    int          cyc;
    int          r;
    logic [47:0] e;
    subkey_ready = 1'b1;
    key_in  = k;
    decrypt = dm;
    start   = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    for (int i = 0; i < 16; i++) begin
      r = dm ? 15 - i : i;
      e = (sel == 0) ? kstd[r] : (sel == 1) ? klsb[r] : 48'h0;
      chk($sformatf("%s valid r%0d", nm, r), 64'(subkey_valid), 64'd1);
      chk($sformatf("%s round i%0d", nm, i), 64'(round), 64'(r));
      chk($sformatf("%s subkey r%0d", nm, r), 64'(subkey), 64'(e));
      if (i == stall_at) begin
        subkey_ready = 1'b0;
        for (int j = 0; j < stall_len; j++) begin
          tick();
          cyc++;
          chk($sformatf("%s stall valid %0d", nm, j), 64'(subkey_valid), 64'd1);
          chk($sformatf("%s stall round %0d", nm, j), 64'(round), 64'(r));
          chk($sformatf("%s stall subkey %0d", nm, j), 64'(subkey), 64'(e));
        end
        subkey_ready = 1'b1;
      end
      if (i == poke_at) begin
        start   = 1'b1;
        key_in  = '0;
        decrypt = ~dm;
      end
      tick();
      cyc++;
      start = 1'b0;
    end
    chk({nm, " done"}, 64'(done), 64'd1);
    chk({nm, " busy low"}, 64'(busy), 64'd0);
    chk({nm, " valid low"}, 64'(subkey_valid), 64'd0);
    chk({nm, " done latency"}, 64'(cyc), 64'(17 + stall_len));
    tick();
    chk({nm, " done pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    #2;
    chk("reset subkey", 64'(subkey), 64'd0);
    chk("reset valid", 64'(subkey_valid), 64'd0);
    chk("reset round", 64'(round), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    run("enc", KSTD, 1'b0, 0, -1, 0, -1);
    chk("enc last subkey held", 64'(subkey), 64'(kstd[15]));
    chk("enc last round held", 64'(round), 64'd15);
    run("dec", KSTD, 1'b1, 0, -1, 0, -1);
    run("bp", KSTD, 1'b0, 0, 4, 3, -1);
    run("poke", KSTD, 1'b0, 0, -1, 0, 7);

    // Reset in the middle of a schedule.
    subkey_ready = 1'b1;
    key_in  = KSTD;
    decrypt = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("pre-rst round", 64'(round), 64'd9);
    #1 rst = 1'b1;
    #1;
    chk("rst async subkey", 64'(subkey), 64'd0);
    chk("rst async valid", 64'(subkey_valid), 64'd0);
    chk("rst async round", 64'(round), 64'd0);
    chk("rst async busy", 64'(busy), 64'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rst no done %0d", i), 64'(done), 64'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("post-rst no done %0d", i), 64'(done), 64'd0);
    end
    run("post-rst", KSTD, 1'b0, 0, -1, 0, -1);

    run("zero", 56'h0, 1'b0, 2, -1, 0, -1);
    run("lsb", 56'h1, 1'b0, 1, -1, 0, -1);
    run("lsb-dec", 56'h1, 1'b1, 1, -1, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
